mult_share_ctrl: RTL and testbench
==================================

// Module: mult_share_ctrl
// PURPOSE
//  Shares one registered signed multiplier (1-cycle latency, CE=0 clears product) among N_REQ requesters.
//  Round-robin arbitration, per-requester valid/ready request ports, one tagged valid/ready response port.
//  Sits between the FDTD update engines and the shared multiplier, which is connected externally via mult_* ports.
// PARAMETERS
//  WIDTH   32  operand width (signed); product is 2*WIDTH
//  N_REQ   4   number of requesters, >=2
//  ID_W    $clog2(N_REQ)  response tag width (derived, not overridable)
// PORTS
//  CLK        in   1              clock, all logic on posedge
//  RST        in   1              reset, asynchronous, active-high
//  req_valid  in   N_REQ          request pending, per requester
//  req_ready  out  N_REQ          one-hot grant/accept, at most one bit high
//  req_a      in   N_REQ*WIDTH    signed operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N_REQ*WIDTH    signed operand B, same packing
//  rsp_valid  out  1              product available
//  rsp_ready  in   1              consumer accepts product
//  rsp_id     out  ID_W           index of requester that issued the product
//  rsp_p      out  2*WIDTH        signed product
//  mult_ce    out  1              multiplier clock enable
//  mult_a     out  WIDTH          multiplier operand A (registered)
//  mult_b     out  WIDTH          multiplier operand B (registered)
//  mult_p     in   2*WIDTH        multiplier product, valid 1 cycle after mult_ce=1
//  op_count   out  32             completed responses since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, mult_ce=0, mult_a/mult_b=0, op_count=0, rr ptr=N_REQ-1.
//  FSM, 3 states:
//  - IDLE: mult_ce=0. If any req_valid, grant winner g. req_ready[g]=1 combinationally in the same cycle.
//    Latch req_a[g], req_b[g] into mult_a/mult_b and g into the id reg. Update rr ptr to g. Next state ISSUE.
//  - ISSUE: mult_ce=1, req_ready=0. Next state RESP unconditionally.
//  - RESP: mult_ce=1 with operands held, so mult_p stays constant. rsp_valid=1, rsp_p=mult_p, rsp_id=id reg.
//    On rsp_valid&&rsp_ready: op_count++ and next state IDLE. Otherwise stay in RESP.
//  Latency: accept edge t -> rsp_valid high from cycle t+2. Max throughput is 1 op per 3 cycles.
//  Arbitration: the search starts at ptr+1 mod N_REQ. The first req_valid found wins.
//    Requester 0 wins first after reset. A continuously-valid requester gets at most 1 grant per N_REQ grants
//    while others are waiting.
//  Handshake: requests are accepted only in IDLE. req_a/req_b are sampled only on the accept cycle.
//    Deasserting req_valid before grant is legal; that request is simply not served.
//    rsp_p, rsp_id and rsp_valid stay stable until accepted. No response is ever dropped.
//  Arithmetic: signed WIDTH x WIDTH -> 2*WIDTH, done fully by the external multiplier. No truncation here.
//  mult_ce=0 in IDLE is deliberate: the multiplier output clears to 0, so idle mult_p=0.
//  Reset mid-operation: the in-flight op is discarded. Outputs go immediately to reset values.
//    No response is produced after RST deasserts, and the rr ptr returns to N_REQ-1.
//  Simultaneous events: in RESP, req_valid is ignored even when rsp_ready=1.
//    The new grant happens in the following IDLE cycle.
// STRUCTURE
//  Package mult_share_pkg: typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} ms_state_t; localparam MULT_LATENCY=1.
//  Sub-module rr_arbiter #(N): inputs req[N], en, ptr update on en&&|req. Outputs one-hot gnt[N] and binary gnt_idx.
//  Top: FSM, operand/id registers, op_count counter, operand mux.
// TESTING
//  1 Single request: req_valid[2]=1, a=7, b=-3 -> req_ready[2] for 1 cycle; 2 cycles later rsp_valid, rsp_p=-21, rsp_id=2.
//  2 All four requesters valid from reset, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. One response every 3 cycles.
//  3 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_p/rsp_id stable, mult_ce=1, no new req_ready;
//    release -> op_count+1.
//  4 Extremes, WIDTH=32: a=-2^31, b=-2^31 -> rsp_p=2^62. a=2^31-1, b=-1 -> rsp_p=-(2^31-1).
//  5 Reset in ISSUE and in RESP -> outputs at reset values same cycle. Next grant goes to requester 0. No stale rsp_valid.
//  6 Fairness: req0 held valid, req3 raised once -> req3 granted within 2 grants. No grant to idle requesters.

Source files
------------

// File: rtl/mult_share_ctrl_pkg.sv
// Shared types for the multiplier-sharing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_share_pkg;

  // Controller FSM: grant in IDLE, fire the multiplier in ISSUE, hold the product in RESP.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } ms_state_t;

  // Register stages inside the external multiplier (operands in -> product out).
  localparam int MULT_LATENCY = 1;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Bundle of request, response and multiplier-side signals around the shared multiplier.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the single response.
//
// Signals:
//   req_valid/req_ready [N_REQ]     per-requester handshake, req_ready is one-hot or zero
//   req_a/req_b [N_REQ*WIDTH]       signed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready, rsp_id, rsp_p  tagged product response
//   mult_ce, mult_a, mult_b, mult_p     external registered multiplier connection
//   op_count [32]                   completed responses since reset
// Modports: slave = the controller, master = everything around it (engines, consumer, multiplier).
interface mult_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [2*WIDTH-1:0]     rsp_p;
  logic                   mult_ce;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [2*WIDTH-1:0]     mult_p;
  logic [31:0]            op_count;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_p,
    output req_ready, rsp_valid, rsp_id, rsp_p, mult_ce, mult_a, mult_b, op_count
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_p,
    input  req_ready, rsp_valid, rsp_id, rsp_p, mult_ce, mult_a, mult_b, op_count
  );

endinterface

// File: rtl/mult_share_ctrl_arb.sv
// Round-robin arbiter: search starts one past the last winner, first pending request wins.
// Latency: combinational grant; pointer updates on the clock edge of an enabled, non-empty cycle.
// Backpressure: none of its own; i_en gates both the grant and the pointer update.
//
// Ports:
//   i_clk, i_rst      clock, async active-high reset (pointer returns to N-1 so index 0 wins first)
//   i_req [N]         pending requests
//   i_en              arbitration allowed this cycle
//   o_gnt [N]         one-hot grant, zero when disabled or nothing pending
//   o_gnt_idx         binary index of the winner (meaningful only when o_gnt != 0)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_gnt_idx
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Walk the ring starting at ptr+1; k=N lands back on ptr itself, so the last
  // winner is considered only after everyone else.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (i_en && w_found) begin
      o_gnt[w_idx] = 1'b1;
    end
  end

  assign o_gnt_idx = w_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (i_en && |i_req) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one external registered signed multiplier among N_REQ requesters, round-robin.
// Latency: accept edge t -> rsp_valid from cycle t+2; at most one operation per 3 cycles.
// Backpressure: rsp_ready low holds RESP with operands and product frozen; no new grants meanwhile.
//
// Ports:
//   CLK, RST   clock, async active-high reset (discards any in-flight operation)
//   bus        mult_share_ctrl_if.slave: request ports, tagged response, multiplier side, op_count
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input logic              CLK,
  input logic              RST,
  mult_share_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  ms_state_t        r_state;
  ms_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_mult_a;
  logic [WIDTH-1:0] r_mult_b;
  logic [ID_W-1:0]  r_id;
  logic [31:0]      r_op_count;

  logic             w_arb_en;
  logic             w_accept;
  logic             w_rsp_fire;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // Grants only in IDLE. RST is folded in so req_ready reads 0 while reset is
  // held, even though the state register already sits in IDLE.
  assign w_arb_en   = (r_state == S_IDLE) && !RST;
  assign w_accept   = w_arb_en && |bus.req_valid;
  assign w_rsp_fire = (r_state == S_RESP) && bus.rsp_ready;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_req     (bus.req_valid),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_sel_a = bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_sel_b = bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_mult_a   <= '0;
      r_mult_b   <= '0;
      r_id       <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Operands are captured only on the accept edge and then held through
      // ISSUE and RESP, which keeps the multiplier output constant under backpressure.
      if (w_accept) begin
        r_mult_a <= w_sel_a;
        r_mult_b <= w_sel_b;
        r_id     <= w_gnt_idx;
      end
      if (w_rsp_fire) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  // CE is dropped in IDLE on purpose so the idle multiplier output clears to 0.
  assign bus.mult_ce   = (r_state == S_ISSUE) || (r_state == S_RESP);
  assign bus.mult_a    = r_mult_a;
  assign bus.mult_b    = r_mult_b;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_p     = bus.mult_p;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed vector table plus multi-cycle corner sequences.
// Models the external registered multiplier (CE=0 clears the product).
module tb_mult_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.WIDTH(32), .N_REQ(4)) bus ();

  mult_share_ctrl #(.WIDTH(32), .N_REQ(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // External multiplier model
  logic [63:0] mul_p = '0;
  always @(posedge clk) begin
    if (bus.mult_ce)
      mul_p <= $signed({{32{bus.mult_a[31]}}, bus.mult_a}) * $signed({{32{bus.mult_b[31]}}, bus.mult_b});
    else
      mul_p <= '0;
  end
  assign bus.mult_p = mul_p;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mult_ce", 64'(bus.mult_ce), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Accept whatever response is pending, bounded.
  task automatic drain(input string nm);
    bit got;
    got = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (bus.rsp_valid) got = 1'b1;
      step();
    end
    bus.rsp_ready = 1'b0;
    if (got) exp_cnt++;
    chk(nm, 64'(got), 64'd1);
  endtask

  initial begin
    int ids[$];
    int cyc[$];
    int grants[$];
    int bad;
    bit clr3;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{2, 32'd7, -32'sd3, -64'sd21};
    vecs[1] = '{0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, -64'sd2147483647};
    vecs[3] = '{3, 32'd0, 32'd12345, 64'd0};
    vecs[4] = '{1, -32'sd5, -32'sd6, 64'd30};
    vecs[5] = '{0, 32'd100000, 32'd300000, 64'd30000000000};

    step();
    do_reset();
    chk("rst_mult_a", 64'(bus.mult_a), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);

    // Single requests: grant, latency, operand sampling, product, tag, count
    foreach (vecs[v]) begin
      bus.req_valid = '0;
      bus.req_valid[vecs[v].idx] = 1'b1;
      bus.req_a[vecs[v].idx*32 +: 32] = vecs[v].a;
      bus.req_b[vecs[v].idx*32 +: 32] = vecs[v].b;
      #1;
      chk($sformatf("v%0d_grant", v), 64'(bus.req_ready), 64'(1) << vecs[v].idx);
      chk($sformatf("v%0d_idle_ce", v), 64'(bus.mult_ce), 64'd0);
      step();
      bus.req_valid = '0;
      bus.req_a[vecs[v].idx*32 +: 32] = 32'hDEAD_BEEF;
      bus.req_b[vecs[v].idx*32 +: 32] = 32'h1234_5678;
      #1;
      chk($sformatf("v%0d_issue_ce", v), 64'(bus.mult_ce), 64'd1);
      chk($sformatf("v%0d_issue_vld", v), 64'(bus.rsp_valid), 64'd0);
      chk($sformatf("v%0d_mult_a", v), {32'd0, bus.mult_a}, {32'd0, vecs[v].a});
      step();
      chk($sformatf("v%0d_rsp_vld", v), 64'(bus.rsp_valid), 64'd1);
      chk($sformatf("v%0d_rsp_p", v), bus.rsp_p, vecs[v].p);
      chk($sformatf("v%0d_rsp_id", v), 64'(bus.rsp_id), 64'(vecs[v].idx));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      exp_cnt++;
      #1;
      chk($sformatf("v%0d_op_count", v), 64'(bus.op_count), 64'(exp_cnt));
      chk($sformatf("v%0d_after_vld", v), 64'(bus.rsp_valid), 64'd0);
    end

    // All four valid from reset: ids 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*32 +: 32] = 32'(i + 1);
      bus.req_b[i*32 +: 32] = 32'd10;
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 60 && ids.size() < 5; c++) begin
      #1;
      if (!$onehot0(bus.req_ready)) bad++;
      if (bus.rsp_valid) begin
        ids.push_back(int'(bus.rsp_id));
        cyc.push_back(c);
        chk("rr_p", bus.rsp_p, 64'((int'(bus.rsp_id) + 1) * 10));
      end
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    chk("rr_count", 64'(ids.size()), 64'd5);
    chk("rr_onehot", 64'(bad), 64'd0);
    if (ids.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rr_id%0d", i), 64'(ids[i]), 64'(i % 4));
      for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), 64'(cyc[i] - cyc[i-1]), 64'd3);
    end
    exp_cnt = 5;
    #1;
    chk("rr_op_count", 64'(bus.op_count), 64'(exp_cnt));

    // Backpressure: hold RESP for 10 cycles with everyone requesting
    bus.req_valid = 4'b0010;
    bus.req_a[32 +: 32] = 32'd9;
    bus.req_b[32 +: 32] = 32'd9;
    step();
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_vld", 64'(bus.rsp_valid), 64'd1);
      chk("bp_p", bus.rsp_p, 64'd81);
      chk("bp_id", 64'(bus.rsp_id), 64'd1);
      chk("bp_ce", 64'(bus.mult_ce), 64'd1);
      chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("bp_op_count", 64'(bus.op_count), 64'(exp_cnt));

    // Reset during ISSUE
    do_reset();
    bus.req_a[0 +: 32] = 32'd3;
    bus.req_b[0 +: 32] = 32'd4;
    bus.req_a[64 +: 32] = 32'd5;
    bus.req_b[64 +: 32] = 32'd6;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b1111;
    #1;
    chk("ri_pre_ce", 64'(bus.mult_ce), 64'd1);
    rst = 1'b1;
    #1;
    chk("ri_ce", 64'(bus.mult_ce), 64'd0);
    chk("ri_req_ready", 64'(bus.req_ready), 64'd0);
    chk("ri_mult_a", 64'(bus.mult_a), 64'd0);
    chk("ri_rsp_id", 64'(bus.rsp_id), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ri_grant0", 64'(bus.req_ready), 64'b0001);
    chk("ri_no_stale", 64'(bus.rsp_valid), 64'd0);
    step();
    bus.req_valid = '0;
    #1;
    chk("ri_issue_vld", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("ri_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("ri_rsp_p", bus.rsp_p, 64'd12);
    drain("ri_drain");

    // Reset during RESP
    bus.req_a[32 +: 32] = 32'd2;
    bus.req_b[32 +: 32] = 32'd2;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step();
    chk("rr_pre_vld", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rp_vld", 64'(bus.rsp_valid), 64'd0);
    chk("rp_ce", 64'(bus.mult_ce), 64'd0);
    chk("rp_op_count", 64'(bus.op_count), 64'd0);
    chk("rp_rsp_id", 64'(bus.rsp_id), 64'd0);
    step();
    rst = 1'b0;
    exp_cnt = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rsp_valid) bad++;
      step();
    end
    chk("rp_no_stale", 64'(bad), 64'd0);
    bus.req_valid = 4'b1110;
    #1;
    chk("rp_grant1", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = 4'b1111;
    #1;
    chk("rp_grant0", 64'(bus.req_ready), 64'b0001);
    step();
    drain("rp_drain");
    chk("rp_count_after", 64'(bus.op_count), 64'(exp_cnt));

    // Fairness: req0 held, req3 raised once
    do_reset();
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      clr3 = 1'b0;
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.req_ready[i]) begin
            grants.push_back(i);
            if (i == 1 || i == 2) bad++;
            if (i == 3) clr3 = 1'b1;
          end
        end
      end
      step();
      if (clr3) bus.req_valid[3] = 1'b0;
    end
    bus.req_valid = '0;
    chk("fair_count", 64'(grants.size()), 64'd4);
    chk("fair_idle_grants", 64'(bad), 64'd0);
    if (grants.size() == 4) begin
      chk("fair_g0", 64'(grants[0]), 64'd0);
      chk("fair_g1", 64'(grants[1]), 64'd3);
      chk("fair_g2", 64'(grants[2]), 64'd0);
      chk("fair_g3", 64'(grants[3]), 64'd0);
    end
    for (int i = 0; i < 8; i++) step();
    bus.rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
